cp0_exc_unit: RTL and testbench

Parametrised coprocessor-0 exception/interrupt unit for the single-cycle MIPS core. It merges the CP0 register file and the exception controller into one block and adds Status (IE/EXL/mask), N_IRQ synchronised external interrupt lines with sticky pending bits, fixed exception priority, nesting suppression and ERET. It sits beside the register file: the datapath reads and writes it through MFC0/MTC0, and fetch redirects on `exc_take` (to the handler) or `eret` (to `epc`).

---
 rtl/cp0_exc_if.sv | 30 +++
 rtl/cp0_exc_unit.sv | 146 ++++++++++++++
 tb/tb_cp0_exc_unit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_if.sv
// Datapath-facing bus of the CP0 exception unit: MFC0/MTC0 access,
// exception flags, ERET, external IRQ lines and the redirect outputs.
interface cp0_exc_if #(
  parameter int N_IRQ = 6
);
  logic [4:0]       adr;
  logic             w;
  logic [31:0]      w_data;
  logic [31:0]      pc;
  logic             ov;
  logic             sys;
  logic             brk;
  logic             dz;
  logic             eret;
  logic [N_IRQ-1:0] irq;
  logic [31:0]      out;
  logic [31:0]      epc;
  logic             exc_take;
  logic [4:0]       exc_code;

  modport master (
    output adr, w, w_data, pc, ov, sys, brk, dz, eret, irq,
    input  out, epc, exc_take, exc_code
  );

  modport slave (
    input  adr, w, w_data, pc, ov, sys, brk, dz, eret, irq,
    output out, epc, exc_take, exc_code
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 register file (Status/Cause/EPC) merged with the exception controller:
// fixed-priority synchronous exceptions, synchronised sticky IRQs, nesting and ERET.
module cp0_exc_unit #(
  parameter int N_IRQ       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  cp0_exc_if.slave  bus
);

  localparam logic [4:0] ADR_STATUS = 5'd12;
  localparam logic [4:0] ADR_CAUSE  = 5'd13;
  localparam logic [4:0] ADR_EPC    = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_OV  = 5'd12,
    EXC_DZ  = 5'd15
  } exc_code_e;

  // Architectural state
  logic                                r_ie;
  logic                                r_exl;
  logic [N_IRQ-1:0]                    r_im;
  logic [N_IRQ-1:0]                    r_ip;
  logic [4:0]                          r_exc_code;
  logic [31:0]                         r_epc;

  // IRQ synchroniser chain plus the previous chain output for edge detection
  logic [SYNC_STAGES-1:0][N_IRQ-1:0]   r_sync;
  logic [N_IRQ-1:0]                    r_irq_last;

  logic                                w_wr_status;
  logic                                w_wr_cause;
  logic                                w_wr_epc;
  logic [N_IRQ-1:0]                    w_w1c;
  logic [N_IRQ-1:0]                    w_irq_rise;
  logic                                w_irq_pend;
  logic                                w_take;
  exc_code_e                           w_code;
  logic [31:0]                         w_status;
  logic [31:0]                         w_cause;
  logic [31:0]                         w_out;

  assign w_wr_status = bus.w && (bus.adr == ADR_STATUS);
  assign w_wr_cause  = bus.w && (bus.adr == ADR_CAUSE);
  assign w_wr_epc    = bus.w && (bus.adr == ADR_EPC);

  assign w_w1c       = w_wr_cause ? bus.w_data[8 +: N_IRQ] : '0;
  assign w_irq_rise  = r_sync[SYNC_STAGES-1] & ~r_irq_last;
  assign w_irq_pend  = |(r_ip & r_im);

  // Synchronous faults always win; an interrupt needs IE, no nesting and an unmasked IP.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_take = 1'b1;
    w_code = EXC_INT;
    if (bus.dz) begin
      w_code = EXC_DZ;
    end else if (bus.ov) begin
      w_code = EXC_OV;
    end else if (bus.sys) begin
      w_code = EXC_SYS;
    end else if (bus.brk) begin
      w_code = EXC_BP;
    end else begin
      w_take = r_ie && !r_exl && w_irq_pend;
    end
  end

  assign w_status = {{(24-N_IRQ){1'b0}}, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {{(24-N_IRQ){1'b0}}, r_ip, 1'b0, r_exc_code, 2'b0};

  always_comb begin
    w_out = '0;
    case (bus.adr)
      ADR_STATUS: w_out = w_status;
      ADR_CAUSE:  w_out = w_cause;
      ADR_EPC:    w_out = r_epc;
      default:    w_out = '0;
    endcase
  end

  assign bus.out      = w_out;
  assign bus.epc      = r_epc;
  assign bus.exc_take = w_take;
  assign bus.exc_code = w_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_irq_last <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.irq};
      r_irq_last <= r_sync[SYNC_STAGES-1];
    end
  end

  // A fresh rising edge beats a same-cycle write-1-to-clear on that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ip <= '0;
    end else begin
      r_ip <= (r_ip & ~w_w1c) | w_irq_rise;
    end
  end

  // Ordering matters: MTC0, then ERET, then take; the last assignment to a flop wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      if (w_wr_status) begin
        r_ie  <= bus.w_data[0];
        r_exl <= bus.w_data[1];
        r_im  <= bus.w_data[8 +: N_IRQ];
      end
      if (w_wr_cause) begin
        r_exc_code <= bus.w_data[6:2];
      end
      if (w_wr_epc && !w_take) begin
        r_epc <= bus.w_data;
      end
      if (bus.eret) begin
        r_exl <= 1'b0;
      end
      if (w_take) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_code;
        // A nested fault keeps the outer handler's return address.
        if (!r_exl) begin
          r_epc <= bus.pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus a randomized run
// compared against a word-level model of Status/Cause/EPC and an IRQ sample history.
module tb_cp0_exc_unit;

  localparam int N = 6;
  localparam int S = 2;
  localparam logic [31:0] IP_MASK     = ((32'd1 << N) - 32'd1) << 8;
  localparam logic [31:0] STATUS_MASK = IP_MASK | 32'h3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_exc_if #(.N_IRQ(N)) bus ();

  cp0_exc_unit #(.N_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whole register words plus the irq level seen at recent edges
  logic [31:0]  m_status;
  logic [31:0]  m_cause;
  logic [31:0]  m_epc;
  logic [N-1:0] m_hist [0:S];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] m_code();
    if (bus.dz)  return 5'd15;
    if (bus.ov)  return 5'd12;
    if (bus.sys) return 5'd8;
    if (bus.brk) return 5'd9;
    return 5'd0;
  endfunction

  function automatic logic m_take();
    if (bus.dz || bus.ov || bus.sys || bus.brk) return 1'b1;
    return m_status[0] && !m_status[1] && ((m_cause & m_status & IP_MASK) != 32'h0);
  endfunction

  task automatic m_clear();
    m_status = '0;
    m_cause  = '0;
    m_epc    = '0;
    for (int i = 0; i <= S; i++) m_hist[i] = '0;
  endtask

  task automatic idle();
    bus.adr    = 5'd0;
    bus.w      = 1'b0;
    bus.w_data = 32'h0;
    bus.pc     = 32'h0;
    bus.ov     = 1'b0;
    bus.sys    = 1'b0;
    bus.brk    = 1'b0;
    bus.dz     = 1'b0;
    bus.eret   = 1'b0;
  endtask

  // Advance one clock: model computes the next state from the inputs held across the edge.
  task automatic tick();
    logic [31:0]  st, ca, ep, rise;
    logic         t;
    logic [4:0]   c;
    logic [N-1:0] smp;
    st = m_status; ca = m_cause; ep = m_epc;
    t = m_take(); c = m_code();
    if (bus.w) begin
      case (bus.adr)
        5'd12: st = bus.w_data & STATUS_MASK;
        5'd13: begin
          ca = ca & ~(bus.w_data & IP_MASK);
          ca[6:2] = bus.w_data[6:2];
        end
        5'd14: ep = bus.w_data;
        default: ;
      endcase
    end
    // An irq rise reaches IP S+1 edges after it is first sampled.
    rise = 32'(m_hist[S-1] & ~m_hist[S]) << 8;
    ca = ca | rise;
    if (bus.eret) st[1] = 1'b0;
    if (t) begin
      ep = m_status[1] ? m_epc : bus.pc;
      st[1] = 1'b1;
      ca[6:2] = c;
    end
    smp = bus.irq;
    @(posedge clk);
    m_status = st; m_cause = ca; m_epc = ep;
    for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = smp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.w = 1'b1; bus.adr = 5'd14; bus.w_data = 32'h0000_1234;
    tick();
    bus.adr = 5'd12; bus.w_data = 32'h0000_0103;
    tick();
    idle();
    n_checks++; if (bus.epc !== 32'h1234) begin n_fail++; $display("FAIL pre_reset_epc got=%h exp=%h", bus.epc, 32'h1234); end
    #1 rst_n = 1'b0;
    m_clear();
    for (int a = 12; a <= 14; a++) begin
      bus.adr = 5'(a);
      #1;
      n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL reset_out adr=%0d got=%h exp=0", a, bus.out); end
    end
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL reset_take got=%b exp=0", bus.exc_take); end
    n_checks++; if (bus.exc_code !== 5'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", bus.exc_code); end
    n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", bus.epc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    bus.dz = 1'b1; bus.ov = 1'b1; bus.sys = 1'b1; bus.pc = 32'h0040_0010;
    #1;
    n_checks++; if (bus.exc_take !== 1'b1) begin n_fail++; $display("FAIL prio_take got=%b exp=1", bus.exc_take); end
    n_checks++; if (bus.exc_code !== 5'd15) begin n_fail++; $display("FAIL prio_code got=%0d exp=15", bus.exc_code); end
    tick();
    idle();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out !== 32'h0000_003C) begin n_fail++; $display("FAIL prio_cause got=%h exp=%h", bus.out, 32'h3C); end
    bus.adr = 5'd14; #1;
    n_checks++; if (bus.out !== 32'h0040_0010) begin n_fail++; $display("FAIL prio_epc got=%h exp=%h", bus.out, 32'h400010); end
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL prio_exl got=%b exp=1", bus.out[1]); end
  endtask

  task automatic test_nested();
    bus.brk = 1'b1; bus.pc = 32'h8000_0180;
    #1;
    n_checks++; if (bus.exc_code !== 5'd9) begin n_fail++; $display("FAIL nest_code got=%0d exp=9", bus.exc_code); end
    tick();
    idle();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out[6:2] !== 5'd9) begin n_fail++; $display("FAIL nest_cause got=%0d exp=9", bus.out[6:2]); end
    n_checks++; if (bus.epc !== 32'h0040_0010) begin n_fail++; $display("FAIL nest_epc got=%h exp=%h", bus.epc, 32'h400010); end
  endtask

  task automatic test_irq();
    bus.w = 1'b1; bus.adr = 5'd12; bus.w_data = 32'h0000_0401;
    bus.irq = N'(6'b000100);
    tick();
    idle();
    tick();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out[10] !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b exp=0", bus.out[10]); end
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL irq_early_take got=%b exp=0", bus.exc_take); end
    tick();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out[10] !== 1'b1) begin n_fail++; $display("FAIL irq_ip got=%b exp=1", bus.out[10]); end
    n_checks++; if (bus.exc_take !== 1'b1) begin n_fail++; $display("FAIL irq_take got=%b exp=1", bus.exc_take); end
    n_checks++; if (bus.exc_code !== 5'd0) begin n_fail++; $display("FAIL irq_code got=%0d exp=0", bus.exc_code); end
    bus.pc = 32'h0040_0ABC;
    tick();
    idle();
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out !== 32'h0000_0403) begin n_fail++; $display("FAIL irq_status got=%h exp=%h", bus.out, 32'h403); end
    n_checks++; if (bus.epc !== 32'h0040_0ABC) begin n_fail++; $display("FAIL irq_epc got=%h exp=%h", bus.epc, 32'h400ABC); end
    bus.w = 1'b1; bus.adr = 5'd13; bus.w_data = 32'h0000_0400;
    tick();
    idle();
    tick();
    tick();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL irq_w1c got=%h exp=0", bus.out); end
  endtask

  task automatic test_masked();
    bus.w = 1'b1; bus.adr = 5'd12; bus.w_data = 32'h0000_0001;
    bus.irq = N'(6'b000101);
    tick();
    idle();
    tick();
    tick();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out !== 32'h0000_0100) begin n_fail++; $display("FAIL mask_ip got=%h exp=%h", bus.out, 32'h100); end
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL mask_im_take got=%b exp=0", bus.exc_take); end
    bus.w = 1'b1; bus.adr = 5'd12; bus.w_data = 32'h0000_0103;
    tick();
    idle();
    #1;
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL mask_exl_take got=%b exp=0", bus.exc_take); end
    bus.eret = 1'b1; #1;
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL mask_eret_take got=%b exp=0", bus.exc_take); end
    tick();
    idle();
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out !== 32'h0000_0101) begin n_fail++; $display("FAIL eret_status got=%h exp=%h", bus.out, 32'h101); end
    n_checks++; if (bus.exc_take !== 1'b1) begin n_fail++; $display("FAIL eret_take got=%b exp=1", bus.exc_take); end
    n_checks++; if (bus.exc_code !== 5'd0) begin n_fail++; $display("FAIL eret_code got=%0d exp=0", bus.exc_code); end
    bus.pc = 32'h0000_1000;
    tick();
    bus.w = 1'b1; bus.adr = 5'd13; bus.w_data = 32'h0000_0100;
    tick();
    idle();
  endtask

  task automatic test_collision();
    bus.eret = 1'b1; bus.sys = 1'b1; bus.pc = 32'h0000_2000;
    #1;
    n_checks++; if (bus.exc_code !== 5'd8) begin n_fail++; $display("FAIL coll_code got=%0d exp=8", bus.exc_code); end
    tick();
    idle();
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL coll_exl got=%b exp=1", bus.out[1]); end
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out[6:2] !== 5'd8) begin n_fail++; $display("FAIL coll_cause got=%0d exp=8", bus.out[6:2]); end
    n_checks++; if (bus.epc !== 32'h0000_1000) begin n_fail++; $display("FAIL coll_epc got=%h exp=%h", bus.epc, 32'h1000); end
  endtask

  task automatic test_take_vs_mtc0();
    bus.ov = 1'b1; bus.w = 1'b1; bus.adr = 5'd12; bus.w_data = 32'h0000_0200;
    tick();
    idle();
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out !== 32'h0000_0202) begin n_fail++; $display("FAIL tm_status got=%h exp=%h", bus.out, 32'h202); end
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out[6:2] !== 5'd12) begin n_fail++; $display("FAIL tm_cause got=%0d exp=12", bus.out[6:2]); end
  endtask

  task automatic test_set_vs_w1c();
    bus.irq = N'(6'b000111);
    tick();
    tick();
    bus.w = 1'b1; bus.adr = 5'd13; bus.w_data = 32'h0000_0200;
    tick();
    idle();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out !== 32'h0000_0200) begin n_fail++; $display("FAIL setw1c_ip got=%h exp=%h", bus.out, 32'h200); end
    bus.w = 1'b1; bus.w_data = 32'h0000_0200;
    tick();
    idle();
    bus.adr = 5'd13; #1;
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL setw1c_clear got=%h exp=0", bus.out); end
  endtask

  task automatic test_reset_mid();
    bus.irq = '0;
    tick();
    tick();
    bus.ov = 1'b1; bus.pc = 32'h0000_0055;
    #2 rst_n = 1'b0;
    idle();
    m_clear();
    for (int a = 12; a <= 14; a++) begin
      bus.adr = 5'(a);
      #1;
      n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL rmid_out adr=%0d got=%h exp=0", a, bus.out); end
    end
    n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL rmid_epc got=%h exp=0", bus.epc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.adr = 5'd12; #1;
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL rmid_status got=%h exp=0", bus.out); end
    n_checks++; if (bus.exc_take !== 1'b0) begin n_fail++; $display("FAIL rmid_take got=%b exp=0", bus.exc_take); end
    bus.dz = 1'b1; bus.pc = 32'h0000_0077;
    tick();
    idle();
    n_checks++; if (bus.epc !== 32'h0000_0077) begin n_fail++; $display("FAIL rmid_first_epc got=%h exp=%h", bus.epc, 32'h77); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       bus.adr = 5'd12;
        1:       bus.adr = 5'd13;
        2:       bus.adr = 5'd14;
        default: bus.adr = 5'($urandom);
      endcase
      bus.w      = ($urandom_range(0, 3) == 0);
      bus.w_data = $urandom;
      bus.pc     = $urandom;
      bus.dz     = ($urandom_range(0, 11) == 0);
      bus.ov     = ($urandom_range(0, 11) == 0);
      bus.sys    = ($urandom_range(0, 11) == 0);
      bus.brk    = ($urandom_range(0, 11) == 0);
      bus.eret   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus.irq[$urandom_range(0, N-1)] ^= 1'b1;
      #1;
      n_checks++; if (bus.exc_take !== m_take()) begin n_fail++; $display("FAIL rnd_take i=%0d got=%b exp=%b", i, bus.exc_take, m_take()); end
      n_checks++; if (bus.exc_code !== (m_take() ? m_code() : 5'd0)) begin n_fail++; $display("FAIL rnd_code i=%0d got=%0d exp=%0d", i, bus.exc_code, m_take() ? m_code() : 5'd0); end
      n_checks++; if (bus.out !== m_read(bus.adr)) begin n_fail++; $display("FAIL rnd_out i=%0d adr=%0d got=%h exp=%h", i, bus.adr, bus.out, m_read(bus.adr)); end
      n_checks++; if (bus.epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc i=%0d got=%h exp=%h", i, bus.epc, m_epc); end
      tick();
    end
  endtask

  initial begin
    idle();
    bus.irq = '0;
    m_clear();
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_priority();
    test_nested();
    test_irq();
    test_masked();
    test_collision();
    test_take_vs_mtc0();
    test_set_vs_w1c();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
